clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of phase counters and ratio fields.
REQ-002 SHALL have parameter DEF_HI, default 32, high-phase length in clk cycles after reset.
REQ-003 SHALL have parameter DEF_LO, default 32, low-phase length in clk cycles after reset.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  run request; level-sensitive.
REQ-007 SHALL have port load  input  1  one-cycle strobe capturing div_hi/div_lo as pending ratio.
REQ-008 SHALL have port div_hi  input  CNT_W  requested high-phase length, in cycles.
REQ-009 SHALL have port div_lo  input  CNT_W  requested low-phase length, in cycles.
REQ-010 SHALL have port clk_div  output  1  registered divided clock.
REQ-011 SHALL have port tick_rise  output  1  one-cycle pulse in first cycle clk_div reads 1.
REQ-012 SHALL have port tick_fall  output  1  one-cycle pulse in first cycle clk_div reads 0 after HIGH.
REQ-013 SHALL have port ratio_ack  output  1  one-cycle pulse in the cycle a pending ratio becomes active.

Function
REQ-014 SHALL implement FSM states IDLE, HIGH, LOW with a CNT_W-bit phase counter cnt.
REQ-015 SHALL, in IDLE with en=1, next cycle enter HIGH: clk_div=1, cnt=0, tick_rise=1, pending ratio applied if valid.
REQ-016 SHALL, in HIGH, increment cnt until cnt==hi_act-1, then next cycle enter LOW: clk_div=0, cnt=0, tick_fall=1.
REQ-017 SHALL, in LOW at cnt==lo_act-1, enter HIGH if en=1 (as REQ-015), else IDLE with clk_div=0.
REQ-018 SHALL give period hi_act+lo_act cycles and duty hi_act/(hi_act+lo_act); defaults give divide-by-64, 50 % duty.
REQ-019 SHALL treat a requested value of 0 as 1; minimum period is 2 cycles (divide-by-2).
REQ-020 SHALL, on en deassertion mid-period, finish the current period then go IDLE; no truncated pulse.
REQ-021 SHALL hold load values as pending; a later load before application overwrites the pending value.
REQ-022 SHALL apply pending only at a HIGH entry; ratio_ack pulses that same cycle; pending then clears.
REQ-023 SHALL, when load coincides with a HIGH entry, apply the previously pending value (or none) and keep the new value pending.
REQ-024 SHALL register all outputs; clk_div SHALL never glitch, and no phase SHALL be shorter than its active length.

Reset
REQ-025 SHALL, while rst_n=0, force IDLE, cnt=0, clk_div=0, tick_rise=0, tick_fall=0, ratio_ack=0, pending invalid, hi_act=DEF_HI, lo_act=DEF_LO.
REQ-026 SHALL, on reset mid-operation, abort immediately and discard any pending ratio.
REQ-027 SHALL resume operation on the first rising clk edge after rst_n deasserts, per REQ-015.

Configuration
REQ-028 SHALL, with macro CLK_DIV_PROG_SYNC_EN defined, add input sync_in (1 bit); sync_in=1 with en=1 forces HIGH entry next cycle (REQ-015 actions, pending applied), overriding HIGH/LOW counting.
REQ-029 SHALL, without CLK_DIV_PROG_SYNC_EN, omit sync_in; phase is restarted only by reset or the IDLE exit.

Structure
REQ-030 SHALL place the state enum and DEF_HI/DEF_LO defaults in shared package clk_div_pkg.
REQ-031 SHALL place pending/active ratio storage, zero-to-one substitution and ratio_ack in sub-module clk_div_ratio_reg.

Verification
REQ-032 SHALL cover reset defaults: en=1 after reset -> clk_div high 32, low 32 cycles, repeating; tick_rise every 64 cycles.
REQ-033 SHALL cover reprogramming: load div_hi=3, div_lo=5 mid-HIGH -> current period unchanged; next period 3 high/5 low; ratio_ack once at the boundary.
REQ-034 SHALL cover zero and minimum values: load div_hi=0, div_lo=0 -> clk_div toggles every cycle (divide-by-2).
REQ-035 SHALL cover clean stop: en drops at cycle 10 of HIGH (hi=lo=32) -> period completes, clk_div=0 in IDLE, en=1 again -> tick_rise one cycle later.
REQ-036 SHALL cover simultaneous load at HIGH entry: pending 4/4, new load 7/1 -> 4/4 applied now, 7/1 applied at the next HIGH entry, two ratio_ack pulses.
REQ-037 SHALL cover asynchronous reset mid-LOW with a ratio pending -> outputs zero immediately; restart uses DEF_HI/DEF_LO.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
// Holds the phase FSM encoding and the ratio that is active after reset.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } div_state_t;

    // Phase lengths used from reset until the first programmed ratio lands.
    localparam int CLK_DIV_DEF_HI = 32;
    localparam int CLK_DIV_DEF_LO = 32;

endpackage

// File: rtl/clk_div_ratio_reg.sv
// Ratio storage for the programmable clock divider.
// A load strobe parks the requested high/low lengths as a pending ratio.
// The pending ratio becomes active only when the divider starts a new
// high phase. Requested lengths of zero are stored as one, so the shortest
// possible output period is two clk cycles.
module clk_div_ratio_reg
    import clk_div_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DEF_HI = CLK_DIV_DEF_HI,
    parameter int DEF_LO = CLK_DIV_DEF_LO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] div_hi,
    input  logic [CNT_W-1:0] div_lo,
    input  logic             apply,
    output logic [CNT_W-1:0] hi_act,
    output logic [CNT_W-1:0] lo_act,
    output logic             ratio_ack
);

    // Default lengths, with the same zero-to-one rule as programmed values.
    localparam logic [CNT_W-1:0] RST_HI = (DEF_HI == 0) ? CNT_W'(1) : CNT_W'(DEF_HI);
    localparam logic [CNT_W-1:0] RST_LO = (DEF_LO == 0) ? CNT_W'(1) : CNT_W'(DEF_LO);

    logic [CNT_W-1:0] pend_hi;
    logic [CNT_W-1:0] pend_lo;
    logic             pend_valid;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Promote the pending ratio at a high-phase start. A load arriving on that
    // same edge becomes the new pending ratio instead of being applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_hi    <= RST_HI;
            pend_lo    <= RST_LO;
            pend_valid <= 1'b0;
            hi_act     <= RST_HI;
            lo_act     <= RST_LO;
            ratio_ack  <= 1'b0;
        end else begin
            ratio_ack <= apply && pend_valid;
            if (apply && pend_valid) begin
                hi_act <= pend_hi;
                lo_act <= pend_lo;
            end
            if (load) begin
                pend_hi    <= at_least_one(div_hi);
                pend_lo    <= at_least_one(div_lo);
                pend_valid <= 1'b1;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with independent high and low phase lengths.
// The output clk_div and the tick/ack pulses are all registered.
// Lowering en lets the current period finish before the divider parks.
// Optional feature: define CLK_DIV_PROG_SYNC_EN to add the sync_in input.
// When sync_in and en are both high, a new high phase starts on the next
// cycle, overriding the phase counting.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DEF_HI = CLK_DIV_DEF_HI,
    parameter int DEF_LO = CLK_DIV_DEF_LO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_hi,
    input  logic [CNT_W-1:0] div_lo,
`ifdef CLK_DIV_PROG_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             clk_div,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             ratio_ack
);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clk_div_nxt;
    logic             tick_rise_nxt;
    logic             tick_fall_nxt;
    logic             high_entry;
    logic [CNT_W-1:0] hi_act;
    logic [CNT_W-1:0] lo_act;
    logic             hi_done;
    logic             lo_done;

    assign hi_done = (cnt == hi_act - CNT_W'(1));
    assign lo_done = (cnt == lo_act - CNT_W'(1));

    clk_div_ratio_reg #(
        .CNT_W  (CNT_W),
        .DEF_HI (DEF_HI),
        .DEF_LO (DEF_LO)
    ) u_ratio (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .div_hi    (div_hi),
        .div_lo    (div_lo),
        .apply     (high_entry),
        .hi_act    (hi_act),
        .lo_act    (lo_act),
        .ratio_ack (ratio_ack)
    );

    // Work out the next phase, the counter value and the registered outputs.
    // Any route into HIGH uses the same entry actions.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        clk_div_nxt   = 1'b0;
        tick_rise_nxt = 1'b0;
        tick_fall_nxt = 1'b0;
        high_entry    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    high_entry = 1'b1;
                end
            end
            ST_HIGH: begin
                if (hi_done) begin
                    state_nxt     = ST_LOW;
                    cnt_nxt       = '0;
                    tick_fall_nxt = 1'b1;
                end else begin
                    cnt_nxt     = cnt + CNT_W'(1);
                    clk_div_nxt = 1'b1;
                end
            end
            ST_LOW: begin
                if (lo_done) begin
                    if (en) begin
                        high_entry = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
`ifdef CLK_DIV_PROG_SYNC_EN
        if (sync_in && en) begin
            high_entry = 1'b1;
        end
`endif
        if (high_entry) begin
            state_nxt     = ST_HIGH;
            cnt_nxt       = '0;
            clk_div_nxt   = 1'b1;
            tick_rise_nxt = 1'b1;
            tick_fall_nxt = 1'b0;
        end
    end

    // Hold the phase state and the glitch-free registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            clk_div   <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            clk_div   <= clk_div_nxt;
            tick_rise <= tick_rise_nxt;
            tick_fall <= tick_fall_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog.
// The reference model builds each whole output period as a list of expected
// cycles when the period starts. A new period starts from the pending or
// active ratio whenever the previous list has run dry and en is high.
// If CLK_DIV_PROG_SYNC_EN is defined, sync_in is tied low.
module tb_clk_div_prog;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] div_hi = '0;
    logic [15:0] div_lo = '0;
`ifdef CLK_DIV_PROG_SYNC_EN
    logic        sync_in = 1'b0;
`endif
    logic        clk_div;
    logic        tick_rise;
    logic        tick_fall;
    logic        ratio_ack;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct packed {
        logic cd;
        logic rise;
        logic fall;
        logic ack;
    } exp_t;

    exp_t q[$];
    exp_t exp_now = '0;
    int   m_hi    = 32;
    int   m_lo    = 32;
    int   p_hi    = 0;
    int   p_lo    = 0;
    bit   p_valid = 1'b0;

    clk_div_prog dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .div_hi    (div_hi),
        .div_lo    (div_lo),
`ifdef CLK_DIV_PROG_SYNC_EN
        .sync_in   (sync_in),
`endif
        .clk_div   (clk_div),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .ratio_ack (ratio_ack)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_outputs();
        check_bit("clk_div",   clk_div,   exp_now.cd);
        check_bit("tick_rise", tick_rise, exp_now.rise);
        check_bit("tick_fall", tick_fall, exp_now.fall);
        check_bit("ratio_ack", ratio_ack, exp_now.ack);
    endtask

    task automatic model_reset();
        q.delete();
        p_valid = 1'b0;
        m_hi    = 32;
        m_lo    = 32;
        exp_now = '0;
    endtask

    // Model one rising edge, using the input values in force at that edge.
    task automatic model_edge();
        bit   ack;
        exp_t e;
        if (q.size() == 0 && en) begin
            ack = 1'b0;
            if (p_valid) begin
                m_hi    = p_hi;
                m_lo    = p_lo;
                p_valid = 1'b0;
                ack     = 1'b1;
            end
            for (int i = 0; i < eff(m_hi); i++) begin
                e = '{cd: 1'b1, rise: (i == 0), fall: 1'b0, ack: (i == 0) && ack};
                q.push_back(e);
            end
            for (int i = 0; i < eff(m_lo); i++) begin
                e = '{cd: 1'b0, rise: 1'b0, fall: (i == 0), ack: 1'b0};
                q.push_back(e);
            end
        end
        if (load) begin
            p_hi    = int'(div_hi);
            p_lo    = int'(div_lo);
            p_valid = 1'b1;
        end
        if (q.size() > 0) exp_now = q.pop_front();
        else              exp_now = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge();
        else       exp_now = '0;
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Advance until the chosen pulse is seen; a timeout is a failure.
    task automatic wait_pulse(input string tag, input bit want_fall, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            if (( want_fall && tick_fall === 1'b1) || (!want_fall && tick_rise === 1'b1))
                seen = 1'b1;
        end
        tests_run++;
        assert (seen) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed no pulse, expected one within %0d cycles", tag, budget);
        end
    endtask

    // Assert reset partway through a cycle and check that the outputs clear at once.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_bit("rst_clk_div",   clk_div,   1'b0);
        check_bit("rst_tick_rise", tick_rise, 1'b0);
        check_bit("rst_tick_fall", tick_fall, 1'b0);
        check_bit("rst_ratio_ack", ratio_ack, 1'b0);
    endtask

    initial begin
        int rises[$];
        int acks;

        // Hold reset for a few cycles; all outputs must stay low.
        model_reset();
        run(3);
        check_bit("reset_clk_div", clk_div, 1'b0);
        rst_n = 1'b1;
        run(2);

        // With the default ratio: 32 cycles high, 32 low, a rise every 64 cycles.
        en = 1'b1;
        for (int i = 0; i < 140; i++) begin
            cycle();
            if (tick_rise === 1'b1) rises.push_back(cyc);
        end
        check_bit("default_rise_count", rises.size() >= 2, 1'b1);
        for (int i = 1; i < rises.size(); i++)
            check_bit("default_period_64", (rises[i] - rises[i-1]) == 64, 1'b1);

        // Program 3/5 in the middle of a high phase.
        wait_pulse("wait_rise_a", 1'b0, 100);
        run(5);
        div_hi = 16'd3; div_lo = 16'd5; load = 1'b1;
        cycle();
        load = 1'b0;
        run(90);

        // Zero values fall back to divide-by-two.
        div_hi = 16'd0; div_lo = 16'd0; load = 1'b1;
        cycle();
        load = 1'b0;
        run(20);

        // Lower en ten cycles into a 32/32 high phase, then restart.
        div_hi = 16'd32; div_lo = 16'd32; load = 1'b1;
        cycle();
        load = 1'b0;
        wait_pulse("wait_rise_b", 1'b0, 10);
        run(8);
        en = 1'b0;
        run(70);
        check_bit("idle_clk_div", clk_div, 1'b0);
        en = 1'b1;
        cycle();
        check_bit("restart_rise", tick_rise, 1'b1);

        // A load on the entry edge: 4/4 applies now and 7/1 waits for the next entry.
        en = 1'b0;
        run(70);
        div_hi = 16'd4; div_lo = 16'd4; load = 1'b1;
        cycle();
        load = 1'b0;
        run(2);
        en = 1'b1; div_hi = 16'd7; div_lo = 16'd1; load = 1'b1;
        acks = 0;
        cycle();
        if (ratio_ack === 1'b1) acks++;
        load = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (ratio_ack === 1'b1) acks++;
        end
        check_bit("two_acks", acks == 2, 1'b1);

        // Reset in a low phase while a ratio is pending; the restart must use the defaults.
        wait_pulse("wait_rise_c", 1'b0, 20);
        div_hi = 16'd5; div_lo = 16'd6; load = 1'b1;
        cycle();
        load = 1'b0;
        wait_pulse("wait_fall_c", 1'b1, 20);
        async_reset();
        run(2);
        rst_n = 1'b1;
        run(70);

        // Randomised en, loads and ratios.
        for (int i = 0; i < 600; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 7) == 0);
            div_hi = 16'($urandom_range(0, 6));
            div_lo = 16'($urandom_range(0, 6));
            cycle();
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
